// File: rtl/pcm_pkg.sv
// Shared constants for the PCM command sequencer: PCM opcodes, status codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pcm_pkg;

  // PCM instruction opcodes (Instruction_in encoding)
  localparam logic [2:0] IDLE_IN  = 3'd0;
  localparam logic [2:0] GEN_CHNG = 3'd1;
  localparam logic [2:0] COMPARE  = 3'd2;
  localparam logic [2:0] PROV_ID  = 3'd3;
  localparam logic [2:0] PROV_EXP = 3'd4;
  localparam logic [2:0] STR_CHNG = 3'd5;

  // Status codes reported by the PCM itself
  localparam logic [31:0] ST_SUCCESS   = 32'd0;
  localparam logic [31:0] ST_NOT_FOUND = 32'd1;
  localparam logic [31:0] ST_AUTH_FAIL = 32'd2;
  localparam logic [31:0] ST_FULL      = 32'd3;
  localparam logic [31:0] ST_BUSY      = 32'd4;

  // Status codes generated by the sequencer (PCM never sees these commands)
  localparam logic [31:0] BAD_OP       = 32'd5;
  localparam logic [31:0] LOAD_TIMEOUT = 32'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } seq_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op >= GEN_CHNG) && (op <= STR_CHNG);
  endfunction

  // Store ops report completion on S_c, auth ops on A_c
  function automatic logic op_is_store(input logic [2:0] op);
    return (op == PROV_ID) || (op == PROV_EXP) || (op == STR_CHNG);
  endfunction

  // Ops that need at least one signature word before issue
  function automatic logic op_needs_words(input logic [2:0] op);
    return (op == COMPARE) || (op == PROV_EXP) || (op == STR_CHNG);
  endfunction

  // Ops that need the full signature (otherwise a single word)
  function automatic logic op_full_sig(input logic [2:0] op);
    return (op == COMPARE) || (op == PROV_EXP);
  endfunction

endpackage

// File: rtl/pcm_cmd_sequencer_if.sv
// Bundles the host command, signature-word, PCM and response channels of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready / word_ready / rsp_ready carry all flow control.
// Modports: slave = sequencer view, master = host + PCM view.
interface pcm_cmd_sequencer_if #(
  parameter int SIG_WORDS = 8
);
  // host command channel
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd_op;
  logic [31:0]             cmd_ip_id;
  // signature word channel
  logic                    word_valid;
  logic                    word_ready;
  logic [31:0]             word_data;
  // PCM drive
  logic [2:0]              pcm_instr;
  logic [31:0]             pcm_ip_id;
  logic [32*SIG_WORDS-1:0] pcm_sig;
  logic                    pcm_sig_valid;
  // PCM result
  logic [31:0]             pcm_control;
  logic [31:0]             pcm_status;
  logic                    pcm_comp;
  logic                    pcm_sc;
  logic                    pcm_ac;
  // response channel
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_ok;
  logic                    rsp_comp;
  logic [31:0]             rsp_status;
  logic [31:0]             rsp_control;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ip_id,
    output cmd_ready,
    input  word_valid, word_data,
    output word_ready,
    output pcm_instr, pcm_ip_id, pcm_sig, pcm_sig_valid,
    input  pcm_control, pcm_status, pcm_comp, pcm_sc, pcm_ac,
    output rsp_valid, rsp_ok, rsp_comp, rsp_status, rsp_control,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ip_id,
    input  cmd_ready,
    output word_valid, word_data,
    input  word_ready,
    input  pcm_instr, pcm_ip_id, pcm_sig, pcm_sig_valid,
    output pcm_control, pcm_status, pcm_comp, pcm_sc, pcm_ac,
    input  rsp_valid, rsp_ok, rsp_comp, rsp_status, rsp_control,
    output rsp_ready
  );

endinterface

// File: rtl/pcm_sig_assembler.sv
// Assembles the PUF signature from 32-bit words into a buffer indexed by a saturating word counter.
// Latency: a written word is visible in o_buf_nxt in the same cycle, in the buffer after 1 edge.
// Backpressure: none; the caller only asserts i_wr_en for accepted words.
// Ports: clk, rst (async active-low), i_clr (zero buffer+counter), i_wr_en/i_wr_dat (word write),
//        o_cnt (next slot), o_buf_nxt (buffer value after this edge, includes clear/write).
module pcm_sig_assembler #(
  parameter int SIG_WORDS = 8,
  parameter int CNT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  logic [31:0]             i_wr_dat,
  output logic [CNT_W-1:0]        o_cnt,
  output logic [32*SIG_WORDS-1:0] o_buf_nxt
);

  logic [32*SIG_WORDS-1:0] r_buf;
  logic [CNT_W-1:0]        r_cnt;
  logic [32*SIG_WORDS-1:0] w_buf_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;

  // The next-state value is exported so the sequencer can snapshot the
  // signature on the same edge that writes the last word.
  always_comb begin
    w_buf_nxt = r_buf;
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_buf_nxt = '0;
      w_cnt_nxt = '0;
    end else if (i_wr_en) begin
      for (int k = 0; k < SIG_WORDS; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          w_buf_nxt[32*k +: 32] = i_wr_dat;
        end
      end
      // saturate on the last slot so the counter never wraps back to 0
      if (r_cnt != CNT_W'(SIG_WORDS-1)) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_buf_nxt = w_buf_nxt;

endmodule

// File: rtl/pcm_cmd_sequencer.sv
// Command sequencer in front of the PUF comparison manager: load signature, issue 1-cycle PCM instruction, return result.
// Latency: GEN_CHNG/PROV_ID rsp_valid 3 cycles after accept; COMPARE SIG_WORDS+3 with back-to-back words; bad op 1.
// Backpressure: one command in flight; cmd_ready only in idle, word_ready only while loading, response held until rsp_ready.
// Ports: clk, rst (async active-low), bus (pcm_cmd_sequencer_if.slave: cmd, word, pcm, rsp channels).
// Optional: define PCM_SEQ_WDOG_EN to build the load watchdog (adds parameter WDOG_CYCLES).
module pcm_cmd_sequencer
  import pcm_pkg::*;
#(
  parameter int SIG_WORDS = 8
`ifdef PCM_SEQ_WDOG_EN
  , parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  pcm_cmd_sequencer_if.slave  bus
);

  localparam int SIG_W = 32 * SIG_WORDS;
  localparam int CNT_W = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1;

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;

  logic [2:0]       r_op;
  logic [31:0]      r_ip_id;
  logic [31:0]      r_pcm_ip_id;
  logic [SIG_W-1:0] r_pcm_sig;
  logic             r_rsp_ok;
  logic             r_rsp_comp;
  logic [31:0]      r_rsp_status;
  logic [31:0]      r_rsp_control;

  logic             w_cmd_acc;
  logic             w_word_acc;
  logic             w_last_word;
  logic             w_clr;
  logic             w_load_pcm;
  logic             w_capture;
  logic             w_bad_op;
  logic             w_timeout;
  logic             w_ok;
  logic [31:0]      w_ip_id_src;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_last_slot;
  logic [SIG_W-1:0] w_buf_nxt;

  // ---------------------------------------------------------------- handshakes
  // Gated by rst so cmd_ready is low for the whole reset window.
  assign bus.cmd_ready  = rst && (r_state == S_IDLE);
  assign bus.word_ready = (r_state == S_LOAD);
  assign w_cmd_acc      = bus.cmd_valid && bus.cmd_ready;
  assign w_word_acc     = bus.word_valid && bus.word_ready;

  assign w_last_slot = op_full_sig(r_op) ? CNT_W'(SIG_WORDS-1) : CNT_W'(0);
  assign w_last_word = w_word_acc && (w_cnt == w_last_slot);

  // ---------------------------------------------------------------- watchdog
`ifdef PCM_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wdog_exp;

  // Restarts on every accepted word and whenever the FSM is outside S_LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if ((r_state != S_LOAD) || w_word_acc) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign w_wdog_exp = (r_state == S_LOAD) && !w_word_acc &&
                      (r_wdog == WD_W'(WDOG_CYCLES - 1));
`endif

  // ---------------------------------------------------------------- signature buffer
  pcm_sig_assembler #(
    .SIG_WORDS (SIG_WORDS),
    .CNT_W     (CNT_W)
  ) u_sig_asm (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_wr_en   (w_word_acc),
    .i_wr_dat  (bus.word_data),
    .o_cnt     (w_cnt),
    .o_buf_nxt (w_buf_nxt)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load_pcm  = 1'b0;
    w_capture   = 1'b0;
    w_bad_op    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          w_clr = 1'b1;
          if (!op_is_legal(bus.cmd_op)) begin
            w_bad_op    = 1'b1;
            w_state_nxt = S_RESP;
          end else if (op_needs_words(bus.cmd_op)) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_load_pcm  = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_LOAD: begin
        if (w_last_word) begin
          w_load_pcm  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
`ifdef PCM_SEQ_WDOG_EN
        else if (w_wdog_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
`endif
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // Zero-word ops go straight to issue on the accept edge, before the ID is latched.
  assign w_ip_id_src = (r_state == S_IDLE) ? bus.cmd_ip_id : r_ip_id;
  assign w_ok        = op_is_store(r_op) ? bus.pcm_sc : bus.pcm_ac;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op          <= IDLE_IN;
      r_ip_id       <= '0;
      r_pcm_ip_id   <= '0;
      r_pcm_sig     <= '0;
      r_rsp_ok      <= 1'b0;
      r_rsp_comp    <= 1'b0;
      r_rsp_status  <= '0;
      r_rsp_control <= '0;
    end else begin
      if (w_cmd_acc) begin
        r_op    <= bus.cmd_op;
        r_ip_id <= bus.cmd_ip_id;
      end
      // PCM-facing ID/signature only change on entry to S_ISSUE and hold otherwise
      if (w_load_pcm) begin
        r_pcm_ip_id <= w_ip_id_src;
        r_pcm_sig   <= w_buf_nxt;
      end
      if (w_bad_op || w_timeout) begin
        r_rsp_ok      <= 1'b0;
        r_rsp_comp    <= 1'b0;
        r_rsp_status  <= w_bad_op ? BAD_OP : LOAD_TIMEOUT;
        r_rsp_control <= '0;
      end
      if (w_capture) begin
        r_rsp_ok      <= w_ok;
        r_rsp_comp    <= (r_op == COMPARE) && w_ok && bus.pcm_comp;
        r_rsp_status  <= w_ok ? ST_SUCCESS : bus.pcm_status;
        r_rsp_control <= ((r_op == GEN_CHNG) && w_ok) ? bus.pcm_control : 32'd0;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from state so an async reset forces IDLE_IN immediately.
  assign bus.pcm_instr     = (r_state == S_ISSUE) ? r_op : IDLE_IN;
  assign bus.pcm_sig_valid = (r_state == S_ISSUE) && (r_op == COMPARE);
  assign bus.pcm_ip_id     = r_pcm_ip_id;
  assign bus.pcm_sig       = r_pcm_sig;

  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_ok      = r_rsp_ok;
  assign bus.rsp_comp    = r_rsp_comp;
  assign bus.rsp_status  = r_rsp_status;
  assign bus.rsp_control = r_rsp_control;

endmodule

// File: doc/pcm_cmd_sequencer.md
# pcm_cmd_sequencer

Front-end command sequencer directly upstream of the PUF comparison manager (PCM). It accepts one host command at a time over a valid/ready channel and assembles the 256-bit PUF signature from 32-bit words. It then drives the PCM instruction, IP ID and signature inputs for exactly one cycle and captures the PCM result. The result is returned on a valid/ready response channel.

## Interface
Parameters:
- SIG_WORDS, 8, 32-bit words per PUF signature (256 bits)
- WDOG_CYCLES, 1024, load-watchdog limit in cycles; used only with the watchdog compiled in

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  PCM opcode: 1 GEN_CHNG, 2 COMPARE, 3 PROV_ID, 4 PROV_EXP, 5 STR_CHNG
- cmd_ip_id  in  32  target IP ID
- word_valid  in  1  signature word offered
- word_ready  out  1  signature word accepted
- word_data  in  32  signature word; word k maps to signature bits [32k+31:32k]
- pcm_instr  out  3  to PCM Instruction_in
- pcm_ip_id  out  32  to PCM IP_ID_in
- pcm_sig  out  256  to PCM sig_in
- pcm_sig_valid  out  1  to PCM sig_valid
- pcm_control  in  32  from PCM control_out
- pcm_status  in  32  from PCM status
- pcm_comp  in  1  from PCM comp_out
- pcm_sc  in  1  from PCM S_c
- pcm_ac  in  1  from PCM A_c
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_ok  out  1  operation completed
- rsp_comp  out  1  comparison matched (COMPARE only)
- rsp_status  out  32  status code; 0 when rsp_ok=1
- rsp_control  out  32  challenge (GEN_CHNG with ok only, else 0)

## Operation
- States:
  - S_IDLE: cmd_ready=1. A command is taken when cmd_valid&&cmd_ready.
  - S_LOAD: word_ready=1.
  - S_ISSUE, S_CAPTURE, S_RESP.
- Accept latches op and ip_id and clears the signature buffer and word counter.
- Words needed per op:
  - COMPARE, PROV_EXP: SIG_WORDS.
  - STR_CHNG: 1.
  - GEN_CHNG, PROV_ID: 0, so the FSM goes S_IDLE→S_ISSUE directly.
- An illegal op (0, 6, 7) goes S_IDLE→S_RESP with rsp_ok=0 and rsp_status=BAD_OP (32'd5). The PCM is never driven.
- S_LOAD:
  - Each word_valid&&word_ready writes word_data into slot count, then count++.
  - After the last needed word → S_ISSUE.
  - The counter is 3 bits and never wraps past the needed count.
- S_ISSUE (1 cycle): pcm_instr=op and pcm_ip_id=latched ID. pcm_sig_valid=1 only for COMPARE.
- S_CAPTURE (1 cycle): pcm_instr=0 (IDLE_IN). Response fields are registered at the end of this cycle.
  - Store ops (PROV_ID, PROV_EXP, STR_CHNG): ok=pcm_sc.
  - Auth ops (GEN_CHNG, COMPARE): ok=pcm_ac.
  - rsp_comp=pcm_comp for COMPARE&&ok, else 0.
  - rsp_status=ok?0:pcm_status.
  - rsp_control=pcm_control for GEN_CHNG&&ok, else 0.
- S_RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready; then → S_IDLE. A new command can be accepted on the following cycle.
- pcm_sig and pcm_ip_id hold their value outside S_ISSUE. pcm_instr=0 in every state except S_ISSUE.

## Timing
- Reset values:
  - cmd_ready=0 while reset is asserted, then 1 in S_IDLE.
  - word_ready=0, rsp_valid=0, rsp_ok=0, rsp_comp=0.
  - rsp_status=0, rsp_control=0.
  - pcm_instr=0, pcm_ip_id=0, pcm_sig=0, pcm_sig_valid=0.
  - State=S_IDLE.
- Reset asserted mid-operation aborts immediately. pcm_instr drops to 0 asynchronously, so no partial instruction reaches the PCM.
- GEN_CHNG/PROV_ID latency: accept at edge 0, ISSUE in cycle 1, CAPTURE in cycle 2, rsp_valid from cycle 3.
- COMPARE with back-to-back words: rsp_valid at cycle SIG_WORDS+3 after accept.
- word_valid while not in S_LOAD is ignored (word_ready=0).
- cmd_valid outside S_IDLE is ignored.
- rsp_ready asserted while rsp_valid=0 has no effect.

## Configuration
- PCM_SEQ_WDOG_EN defined:
  - In S_LOAD, a counter resets on every accepted word.
  - When it reaches WDOG_CYCLES-1 without a word, the FSM goes to S_RESP with rsp_ok=0 and rsp_status=LOAD_TIMEOUT (32'd6). The PCM is not driven.
- Undefined: S_LOAD waits indefinitely, and no watchdog logic is built.

## Structure
- Package pcm_pkg holds:
  - PCM opcode constants (IDLE_IN..STR_CHNG) and PCM status codes (0–4).
  - Sequencer codes BAD_OP=5 and LOAD_TIMEOUT=6.
  - The state enum.
- Sub-module pcm_sig_assembler holds the 256-bit buffer, word counter, clear and write-enable. The sequencer FSM owns everything else.

## Test plan
- PROV_ID id=0xA5A5_0001, pcm_sc=1 in CAPTURE → pcm_instr=3 for exactly 1 cycle; rsp_ok=1, rsp_status=0, rsp_valid at cycle 3.
- COMPARE with words 0x0..0x7 back-to-back, pcm_ac=1, pcm_comp=1 → pcm_sig[31:0]=0, pcm_sig[255:224]=7, pcm_sig_valid=1 only in ISSUE; rsp_ok=1, rsp_comp=1.
- GEN_CHNG with pcm_ac=0, pcm_status=2 → rsp_ok=0, rsp_status=2, rsp_control=0.
- cmd_op=6 → no pcm_instr activity; rsp_ok=0, rsp_status=5, rsp_valid at cycle 1.
- rsp_ready held low for 10 cycles → response stable and cmd_ready=0 throughout; accepted on rsp_ready=1.
- With PCM_SEQ_WDOG_EN and WDOG_CYCLES=16: PROV_EXP with 3 words then a stall → rsp_status=6 and pcm_instr stays 0. Separately, rst low during LOAD → all outputs at reset values.
